// File: rtl/transmissor_status_elevador.sv
// Serialises the elevator status frame (header, slot bytes, 0x0A) over a UART 8N1 TX line.
// Optional periodic auto-send is compiled in with the STATUS_TX_AUTO_EN macro.
module transmissor_status_elevador #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int N_SLOTS      = 4,
    parameter int PERIODO_AUTO = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       envia,
    input  logic [1:0] andar_atual,
    input  logic       sentido,
    output logic [1:0] slot_addr,
    input  logic [1:0] slot_tipo,
    input  logic [1:0] slot_destino,
    output logic       TX,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     N_BYTES   = 3'(N_SLOTS + 2);
    localparam logic [2:0]     N_SLOTS_B = 3'(N_SLOTS);

    generate
        if (N_SLOTS < 1 || N_SLOTS > 4 || CLKS_PER_BIT < 1 || PERIODO_AUTO < 1) begin : g_param_invalido
            $error("transmissor_status_elevador: parameter out of range");
        end
    endgenerate

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        PREPARA   = 4'd1,
        TRANSMITE = 4'd2,
        FIM       = 4'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [2:0]    idx_q, idx_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [1:0]    andar_q, andar_d;
    logic          sentido_q, sentido_d;

    logic          pedido;
    logic          em_slot;
    logic [2:0]    idx_m1;
    logic [2:0]    idx_prox;
    logic [7:0]    byte_atual;

`ifdef STATUS_TX_AUTO_EN
    localparam int            AW       = (PERIODO_AUTO > 1) ? $clog2(PERIODO_AUTO) : 1;
    localparam logic [AW-1:0] AUTO_MAX = AW'(PERIODO_AUTO - 1);

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_wrap;

    always_comb begin
        auto_wrap  = (auto_cnt_q == AUTO_MAX);
        auto_cnt_d = auto_wrap ? '0 : auto_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    // A wrap that lands while a frame is in flight is simply lost: pedido is only looked at in OCIOSO.
    assign pedido = envia | auto_wrap;
`else
    assign pedido = envia;
`endif

    // Byte 0 is the header, bytes 1..N_SLOTS map to RAM slots 0..N_SLOTS-1, the last is the terminator.
    always_comb begin
        idx_m1    = idx_q - 3'd1;
        idx_prox  = idx_q + 3'd1;
        em_slot   = (idx_q != 3'd0) && (idx_q <= N_SLOTS_B);
        slot_addr = em_slot ? idx_m1[1:0] : 2'd0;
        if (idx_q == 3'd0) begin
            byte_atual = {2'b10, 3'b000, sentido_q, andar_q};
        end else if (em_slot) begin
            byte_atual = {2'b01, idx_m1[1:0], slot_tipo, slot_destino};
        end else begin
            byte_atual = 8'h0A;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        andar_d   = andar_q;
        sentido_d = sentido_q;
        case (estado_q)
            OCIOSO: begin
                tx_d = 1'b1;
                if (pedido) begin
                    andar_d   = andar_atual;
                    sentido_d = sentido;
                    idx_d     = 3'd0;
                    estado_d  = PREPARA;
                end
            end
            PREPARA: begin
                // The start bit goes out right away; the shifter holds d0..d7 plus the stop bit.
                shift_d  = {1'b1, byte_atual};
                tx_d     = 1'b0;
                cnt_d    = '0;
                bit_d    = 4'd0;
                estado_d = TRANSMITE;
            end
            TRANSMITE: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        tx_d     = 1'b1;
                        idx_d    = idx_prox;
                        estado_d = (idx_prox < N_BYTES) ? PREPARA : FIM;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b1, shift_q[8:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIM: begin
                tx_d     = 1'b1;
                estado_d = OCIOSO;
            end
            default: begin
                tx_d     = 1'b1;
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            idx_q     <= 3'd0;
            shift_q   <= 9'h1FF;
            tx_q      <= 1'b1;
            andar_q   <= 2'd0;
            sentido_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            andar_q   <= andar_d;
            sentido_q <= sentido_d;
        end
    end

    assign TX        = tx_q;
    assign ocupado   = (estado_q != OCIOSO);
    assign pronto    = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_transmissor_status_elevador.sv
// Bench for transmissor_status_elevador: table vectors, random frames against a byte-level model,
// and hand-written corner sequences; TX is decoded by a generic UART receiver.
module tb_transmissor_status_elevador;

    localparam int CPB    = 4;
    localparam int NSL    = 4;
    localparam int NS     = 300;
    localparam int BYTE_C = 1 + 10 * CPB;
    localparam int FRAME_C = (NSL + 2) * BYTE_C;

    typedef logic [5:0][7:0] frame_t;

    typedef struct packed {
        logic [1:0]      andar;
        logic            sentido;
        logic [3:0][1:0] tipo;
        logic [3:0][1:0] dest;
        frame_t          exp_b;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       envia;
    logic [1:0] andar_atual;
    logic       sentido;
    logic [1:0] slot_addr;
    logic [1:0] slot_tipo;
    logic [1:0] slot_destino;
    logic       TX;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [1:0] ram_tipo [4];
    logic [1:0] ram_dest [4];

    logic       tr_tx [NS];
    logic       tr_oc [NS];
    logic       tr_pr [NS];
    logic [1:0] tr_sa [NS];

    int n_cmp = 0;
    int n_err = 0;

    transmissor_status_elevador #(
        .CLKS_PER_BIT (CPB),
        .N_SLOTS      (NSL),
        .PERIODO_AUTO (400)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .envia        (envia),
        .andar_atual  (andar_atual),
        .sentido      (sentido),
        .slot_addr    (slot_addr),
        .slot_tipo    (slot_tipo),
        .slot_destino (slot_destino),
        .TX           (TX),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    assign slot_tipo    = ram_tipo[slot_addr];
    assign slot_destino = ram_dest[slot_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t model_frame(input logic [1:0] a, input logic s,
                                           input logic [3:0][1:0] t, input logic [3:0][1:0] d);
        frame_t f;
        f[0] = 8'(128 + 4 * int'(s) + int'(a));
        for (int i = 0; i < 4; i++) f[i+1] = 8'(64 + 16 * i + 4 * int'(t[i]) + int'(d[i]));
        f[5] = 8'd10;
        return f;
    endfunction

    task automatic load_ram(input logic [3:0][1:0] t, input logic [3:0][1:0] d);
        for (int i = 0; i < 4; i++) begin
            ram_tipo[i] = t[i];
            ram_dest[i] = d[i];
        end
    endtask

    // Requests one frame and records NS cycles after the envia sample edge; optional mid-frame actions.
    task automatic run_frame(input frame_t exp_f, input string tag, input int chg_at,
                             input int busy_at, input int rst_at);
        int nb, bad_oc, bad_sa, bad_rst, first_pr, n_pr, i;
        int pos [6];
        logic [7:0] got [6];
        logic stp [6];
        logic [1:0] exp_sa;
        nb = 0; bad_oc = 0; bad_sa = 0; bad_rst = 0; first_pr = -1; n_pr = 0;
        for (int b = 0; b < 6; b++) begin got[b] = 8'h00; pos[b] = -1; stp[b] = 1'b0; end
        @(negedge clock);
        envia = 1'b1;
        for (int j = 0; j < NS; j++) begin
            @(negedge clock);
            tr_tx[j] = TX; tr_oc[j] = ocupado; tr_pr[j] = pronto; tr_sa[j] = slot_addr;
            envia = (j == busy_at);
            if (j == chg_at) begin andar_atual = 2'd3; sentido = ~sentido; end
            if (j == rst_at) reset = 1'b1;
            if (j == rst_at + 1) reset = 1'b0;
        end
        envia = 1'b0;
        for (int j = 0; j < NS; j++) begin
            if (tr_pr[j] === 1'b1) begin
                n_pr++;
                if (first_pr < 0) first_pr = j;
            end
        end
        if (rst_at >= 0) begin
            for (int j = rst_at + 1; j < NS; j++)
                if (tr_tx[j] !== 1'b1 || tr_oc[j] !== 1'b0 || tr_sa[j] !== 2'd0) bad_rst++;
            check({tag, " after_reset_line"}, 32'(bad_rst), 32'd0);
            check({tag, " pronto_count"}, 32'(n_pr), 32'd0);
            return;
        end
        for (int j = 0; j < NS; j++) begin
            if (tr_oc[j] !== (j <= FRAME_C)) bad_oc++;
            if (j > FRAME_C && tr_tx[j] !== 1'b1) bad_oc++;
            exp_sa = 2'd0;
            if (j < FRAME_C && j / BYTE_C >= 1 && j / BYTE_C <= NSL) exp_sa = 2'(j / BYTE_C - 1);
            if (tr_sa[j] !== exp_sa) bad_sa++;
        end
        check({tag, " pronto_cycle"}, 32'(first_pr), 32'(FRAME_C));
        check({tag, " pronto_count"}, 32'(n_pr), 32'd1);
        check({tag, " ocupado_window"}, 32'(bad_oc), 32'd0);
        check({tag, " slot_addr"}, 32'(bad_sa), 32'd0);
        i = 1;
        while (i + 10 * CPB < NS) begin
            if (tr_tx[i] === 1'b0 && tr_tx[i-1] === 1'b1) begin
                if (nb < 6) begin
                    for (int d = 0; d < 8; d++) got[nb][d] = tr_tx[i + CPB * (1 + d) + CPB / 2];
                    stp[nb] = tr_tx[i + 9 * CPB + CPB / 2];
                    pos[nb] = i;
                end
                nb++;
                i += 10 * CPB;
            end else begin
                i++;
            end
        end
        check({tag, " byte_count"}, 32'(nb), 32'd6);
        for (int b = 0; b < 6; b++) begin
            check($sformatf("%s byte%0d", tag, b), 32'(got[b]), 32'(exp_f[b]));
            check($sformatf("%s start%0d", tag, b), 32'(pos[b]), 32'(1 + BYTE_C * b));
            check($sformatf("%s stop%0d", tag, b), 32'(stp[b]), 32'd1);
        end
    endtask

    initial begin
        vec_t vecs [3];
        frame_t f;
        logic [3:0][1:0] rt, rd;
        int bad_tx, bad_sa;
        int rises [$];
        logic oc_prev;

        vecs[0] = '{andar: 2'd2, sentido: 1'b1,
                    tipo: {2'd3, 2'd2, 2'd0, 2'd1}, dest: {2'd0, 2'd1, 2'd0, 2'd3},
                    exp_b: {8'h0A, 8'h7C, 8'h69, 8'h50, 8'h47, 8'h86}};
        vecs[1] = '{andar: 2'd0, sentido: 1'b0,
                    tipo: {2'd0, 2'd0, 2'd0, 2'd0}, dest: {2'd0, 2'd0, 2'd0, 2'd0},
                    exp_b: {8'h0A, 8'h70, 8'h60, 8'h50, 8'h40, 8'h80}};
        vecs[2] = '{andar: 2'd3, sentido: 1'b1,
                    tipo: {2'd3, 2'd3, 2'd3, 2'd3}, dest: {2'd3, 2'd3, 2'd3, 2'd3},
                    exp_b: {8'h0A, 8'h7F, 8'h6F, 8'h5F, 8'h4F, 8'h87}};

        reset = 1'b1; envia = 1'b0; andar_atual = 2'd0; sentido = 1'b0;
        load_ram('0, '0);
        repeat (3) @(negedge clock);
        check("reset TX", 32'(TX), 32'd1);
        check("reset ocupado", 32'(ocupado), 32'd0);
        check("reset pronto", 32'(pronto), 32'd0);
        check("reset slot_addr", 32'(slot_addr), 32'd0);
        check("reset db_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;

`ifdef STATUS_TX_AUTO_EN
        oc_prev = 1'b0;
        for (int j = 0; j < 1300; j++) begin
            @(negedge clock);
            if (ocupado === 1'b1 && oc_prev === 1'b0) rises.push_back(j);
            oc_prev = ocupado;
        end
        check("auto frame_count", 32'(rises.size()), 32'd3);
        if (rises.size() >= 3) begin
            check("auto period1", 32'(rises[1] - rises[0]), 32'd400);
            check("auto period2", 32'(rises[2] - rises[1]), 32'd400);
        end
`else
        bad_tx = 0; bad_sa = 0;
        for (int j = 0; j < 1000; j++) begin
            @(negedge clock);
            if (TX !== 1'b1 || ocupado !== 1'b0) bad_tx++;
            if (slot_addr !== 2'd0) bad_sa++;
        end
        check("idle TX", 32'(bad_tx), 32'd0);
        check("idle slot_addr", 32'(bad_sa), 32'd0);

        for (int v = 0; v < 3; v++) begin
            andar_atual = vecs[v].andar;
            sentido     = vecs[v].sentido;
            load_ram(vecs[v].tipo, vecs[v].dest);
            run_frame(vecs[v].exp_b, $sformatf("vec%0d", v), -1, -1, -1);
        end

        for (int r = 0; r < 6; r++) begin
            andar_atual = 2'($urandom_range(0, 3));
            sentido     = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                rt[i] = 2'($urandom_range(0, 3));
                rd[i] = 2'($urandom_range(0, 3));
            end
            load_ram(rt, rd);
            f = model_frame(andar_atual, sentido, rt, rd);
            run_frame(f, $sformatf("rand%0d", r), -1, -1, -1);
        end

        andar_atual = vecs[0].andar; sentido = vecs[0].sentido;
        load_ram(vecs[0].tipo, vecs[0].dest);
        run_frame(vecs[0].exp_b, "snapshot", 10, -1, -1);

        andar_atual = vecs[0].andar; sentido = vecs[0].sentido;
        run_frame(vecs[0].exp_b, "busy_envia", -1, 1 + 3 * BYTE_C + 10, -1);
        run_frame(vecs[0].exp_b, "pronto_envia", -1, FRAME_C, -1);

        run_frame(vecs[0].exp_b, "reset_mid", -1, -1, 2 * BYTE_C + 13);
        run_frame(vecs[0].exp_b, "after_reset", -1, -1, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
